frame_scanout: RTL and testbench
================================

Name: frame_scanout

Overview:
- Raster scan-out engine that sits directly upstream of the SRAM pixel read interface.
- Generates 640x480@60 display timing and drives the read interface's bank / word-address / pixel-select inputs.
- Consumes the returned 4-bit pixel and emits it aligned with hsync/vsync/data-enable.
- Upscales the 64x48 stored frame by SCALE in each axis and performs tear-free double-buffer bank swaps during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible clocks per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE, 10, display pixels per stored pixel, both axes (H_ACTIVE = 64*SCALE, V_ACTIVE = 48*SCALE)
- READ_LAT, 1, clocks from bank/addr change to valid pixel from the read interface

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mem_bank  out  1  frame select to read interface (0 = Frame A, 1 = Frame B)
- mem_addr  out  9  word address within frame, 0..383
- mem_pix_sel  out  3  pixel within word, already delayed by READ_LAT
- mem_pixel  in  4  pixel returned by read interface
- swap_req  in  1  single-cycle request to flip display bank
- swap_ack  out  1  single-cycle pulse when the flip takes effect
- pix_out  out  4  output pixel, 0 when not in active video
- de  out  1  data enable
- hsync_n  out  1  active-low hsync
- vsync_n  out  1  active-low vsync
- frame_start  out  1  one-cycle pulse, aligned with first active pixel of each frame

Behaviour:
- Reset values: counters 0, mem_bank 0, swap pending 0, pix_out 0, de 0, hsync_n 1, vsync_n 1, swap_ack 0, frame_start 0, pixel-select pipe 0.
- hcnt counts 0..H_TOTAL-1 (800) and wraps; vcnt increments on hcnt wrap and wraps at V_TOTAL-1 (524). Active region: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Sync windows:
  - hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- Scaling uses no divider:
  - xsub runs 0..SCALE-1; xsrc (6b) increments on xsub wrap; both clear at hcnt wrap.
  - ysub/ysrc (6b) do the same on line wrap inside active lines; both clear at vcnt wrap.
- Address, registered off the counters:
  - mem_addr = {ysrc, xsrc[5:3]}, i.e. ysrc*8 + xsrc[5:3].
  - Raw select = xsrc[2:0].
  - During blanking mem_addr holds its last value; its content is don't-care.
- Pipeline:
  - Raw select passes through a READ_LAT delay line and becomes mem_pix_sel, so it meets mem_pixel in the same cycle.
  - mem_pixel is registered into pix_out, gated to 0 when delayed de is 0.
  - de, hsync_n, vsync_n and frame_start are delayed by the same total, so outputs trail the counter state by READ_LAT+2 clocks (1 for the address register, READ_LAT for the read, 1 for the output register).
- Bank swap:
  - swap_req sets pending.
  - At the swap point (hcnt == 0 and vcnt == V_ACTIVE, first blanking line), if pending (or swap_req is high that same cycle): mem_bank toggles, swap_ack pulses for that cycle, pending clears.
  - swap_req arriving while pending is already set is absorbed; one flip per frame maximum.
  - swap_req in the cycle after the swap point sets pending for the next frame.
  - mem_bank never changes while the counters are in the active region.
- Reset mid-frame: everything returns to reset values immediately; scan restarts at hcnt = vcnt = 0 with bank 0 after release.

Decomposition:
- Shared package video_pkg holds:
  - the 640x480 timing constants;
  - FRAME_W = 64, FRAME_H = 48, WORDS_PER_LINE = 8, FRAME_WORDS = 384;
  - pixel_t (logic [3:0]).
- One sub-module, delay_pipe: parameterised WIDTH/DEPTH register chain, async active-low reset to 0, DEPTH = 0 means passthrough. Used for mem_pix_sel and for the de/sync/frame_start bundle.

Test Plan:
- Reset release, count 800*525 clocks -> exactly one vsync_n low of 2 lines per frame, 525 hsync_n low pulses of 96 clocks, 307200 de-high cycles per frame.
- Model memory with word n = {8{n[3:0]}} and READ_LAT = 1 -> for display pixel (x, y), pix_out = ((y/10)*8 + (x/10)/8) & 4'hF, aligned with de; 0 outside de.
- Probe addresses -> mem_addr takes values 0..7 on display line 0, 376..383 on line 479, and each address is held for 8*SCALE = 80 clocks.
- Pulse swap_req mid-frame -> swap_ack at hcnt 0 / vcnt 480 only, mem_bank 0->1, no bank change in active video. Pulse swap_req twice in one frame -> only one flip.
- Assert swap_req exactly on the swap-point cycle -> flip occurs that cycle and no second flip next frame.
- Assert rst_n low at vcnt 200 -> all outputs at reset values asynchronously; after release, frame_start occurs READ_LAT+2 clocks later and mem_bank = 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared raster timing constants, stored-frame geometry and pixel type.
// Pure declarations; no logic, no latency.
package video_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_SCALE    = 10;
   localparam int VGA_READ_LAT = 1;

   localparam int FRAME_W        = 64;
   localparam int FRAME_H        = 48;
   localparam int WORDS_PER_LINE = 8;
   localparam int FRAME_WORDS    = 384;

   localparam int ADDR_W = 9;
   localparam int SEL_W  = 3;

   typedef logic [3:0] pixel_t;

endpackage

// File: rtl/delay_pipe.sv
// Fixed-depth register chain, reset to zero; DEPTH = 0 is a wire.
// Latency DEPTH clocks; free-running, no backpressure.
module delay_pipe
   import video_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= '0;
               end
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/frame_scanout.sv
// Raster scan-out: display timing, scaled frame-buffer addressing, bank flips in vblank.
// Outputs trail the counters by READ_LAT+2 clocks; free-running, no backpressure.
module frame_scanout
   import video_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int SCALE    = VGA_SCALE,
   parameter int READ_LAT = VGA_READ_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_bank,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [SEL_W-1:0]  mem_pix_sel,
   input  pixel_t            mem_pixel,
   input  logic              swap_req,
   output logic              swap_ack,
   output pixel_t            pix_out,
   output logic              de,
   output logic              hsync_n,
   output logic              vsync_n,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int SW      = $clog2(SCALE + 1);

   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [VW-1:0]     vcnt_q, vcnt_d;
   logic [SW-1:0]     xsub_q, xsub_d, ysub_q, ysub_d;
   logic [5:0]        xsrc_q, xsrc_d, ysrc_q, ysrc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              bank_q, bank_d;
   logic              pend_q, pend_d;
   logic              ack_q, ack_d;

   logic h_wrap, v_wrap, act_col, act_line, active;
   logic hs_act, vs_act, fs_now, swap_pt, swap_fire;

   logic [3:0] ctl_dly;
   pixel_t     pix_q;
   logic       de_q, hsync_n_q, vsync_n_q, fs_q;

   assign h_wrap   = (hcnt_q == HW'(H_TOTAL - 1));
   assign v_wrap   = (vcnt_q == VW'(V_TOTAL - 1));
   assign act_col  = (hcnt_q < HW'(H_ACTIVE));
   assign act_line = (vcnt_q < VW'(V_ACTIVE));
   assign active   = act_col && act_line;
   assign hs_act   = (hcnt_q >= HW'(H_ACTIVE + H_FP)) && (hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_act   = (vcnt_q >= VW'(V_ACTIVE + V_FP)) && (vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign fs_now   = (hcnt_q == '0) && (vcnt_q == '0);
   assign swap_pt  = (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE));

   always_comb begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      xsub_d = xsub_q;
      xsrc_d = xsrc_q;
      ysub_d = ysub_q;
      ysrc_d = ysrc_q;

      if (h_wrap) begin
         vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
         xsub_d = '0;
         xsrc_d = '0;
      end else if (act_col) begin
         // Source column advances every SCALE display pixels, no divider needed.
         if (xsub_q == SW'(SCALE - 1)) begin
            xsub_d = '0;
            xsrc_d = xsrc_q + 1'b1;
         end else begin
            xsub_d = xsub_q + 1'b1;
         end
      end

      if (h_wrap) begin
         if (v_wrap) begin
            ysub_d = '0;
            ysrc_d = '0;
         end else if (act_line) begin
            if (ysub_q == SW'(SCALE - 1)) begin
               ysub_d = '0;
               ysrc_d = ysrc_q + 1'b1;
            end else begin
               ysub_d = ysub_q + 1'b1;
            end
         end
      end

      addr_d = active ? {ysrc_q, xsrc_q[5:3]} : addr_q;
      sel_d  = active ? xsrc_q[2:0] : sel_q;

      // A request landing on the swap point itself is honoured immediately.
      swap_fire = swap_pt && (pend_q || swap_req);
      bank_d    = bank_q ^ swap_fire;
      ack_d     = swap_fire;
      pend_d    = swap_fire ? 1'b0 : (pend_q | swap_req);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
         xsub_q <= '0;
         xsrc_q <= '0;
         ysub_q <= '0;
         ysrc_q <= '0;
         addr_q <= '0;
         sel_q  <= '0;
         bank_q <= 1'b0;
         pend_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         xsub_q <= xsub_d;
         xsrc_q <= xsrc_d;
         ysub_q <= ysub_d;
         ysrc_q <= ysrc_d;
         addr_q <= addr_d;
         sel_q  <= sel_d;
         bank_q <= bank_d;
         pend_q <= pend_d;
         ack_q  <= ack_d;
      end
   end

   delay_pipe #(.WIDTH(SEL_W), .DEPTH(READ_LAT)) u_sel_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (sel_q),
      .q_o   (mem_pix_sel)
   );

   // Sync polarity is carried active-high so the zero-reset pipe idles deasserted.
   delay_pipe #(.WIDTH(4), .DEPTH(READ_LAT + 1)) u_ctl_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({fs_now, vs_act, hs_act, active}),
      .q_o   (ctl_dly)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q     <= '0;
         de_q      <= 1'b0;
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         fs_q      <= 1'b0;
      end else begin
         pix_q     <= ctl_dly[0] ? mem_pixel : '0;
         de_q      <= ctl_dly[0];
         hsync_n_q <= ~ctl_dly[1];
         vsync_n_q <= ~ctl_dly[2];
         fs_q      <= ctl_dly[3];
      end
   end

   assign mem_bank    = bank_q;
   assign mem_addr    = addr_q;
   assign swap_ack    = ack_q;
   assign pix_out     = pix_q;
   assign de          = de_q;
   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout on a reduced raster (SCALE 2, 144x102 total).
module tb_frame_scanout;

   localparam int HA = 128, HFP = 4, HSY = 8, HBP = 4;
   localparam int VA = 96,  VFP = 2, VSY = 2, VBP = 2;
   localparam int S  = 2;
   localparam int HT = 144;
   localparam int VT = 102;
   localparam int FR = HT * VT;

   localparam int REQ1   = 10 * HT + 50;
   localparam int REQ2   = 30 * HT + 7;
   localparam int REQ3   = FR + 96 * HT;
   localparam int REQ4   = 2 * FR + 96 * HT + 1;
   localparam int K_ACK1 = 96 * HT + 1;
   localparam int K_ACK2 = FR + 96 * HT + 1;
   localparam int K_END  = 2 * FR + 96 * HT + 4;
   localparam int K_RST  = 3 * FR + 43 * HT + 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_bank;
   logic [8:0] mem_addr;
   logic [2:0] mem_pix_sel;
   logic [3:0] mem_pixel;
   logic       swap_req;
   logic       swap_ack;
   logic [3:0] pix_out;
   logic       de, hsync_n, vsync_n, frame_start;

   logic [31:0] rd_word;

   int errors = 0;
   int checks = 0;

   int sa, ha, va, ss, hs, vs, so, ho, vo, fi, kk, n;
   int addr_bad, sel_bad, de_bad, hs_bad, vs_bad, fs_bad, pix_bad, bank_bad, ack_bad;
   int de_cnt, hs_low, hs_fall, vs_low, vs_fall, fs_cnt, ack_cnt, line0_chg;
   int a_first, a_l0_end, a_last_beg, a_last_end;
   logic prev_hs, prev_vs, e_de, e_hs_n, e_vs_n, e_fs, e_bank, e_ack;
   logic [3:0] e_pix;
   logic [8:0] prev_addr;

   always #5 clk = ~clk;

   frame_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .SCALE(S), .READ_LAT(1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_bank    (mem_bank),
      .mem_addr    (mem_addr),
      .mem_pix_sel (mem_pix_sel),
      .mem_pixel   (mem_pixel),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .pix_out     (pix_out),
      .de          (de),
      .hsync_n     (hsync_n),
      .vsync_n     (vsync_n),
      .frame_start (frame_start)
   );

   // Read interface model: one clock of latency, bank B holds inverted nibbles.
   always @(posedge clk) begin
      rd_word <= mem_bank ? {8{~mem_addr[3:0]}} : {8{mem_addr[3:0]}};
   end
   assign mem_pixel = rd_word[{mem_pix_sel, 2'b00} +: 4];

   function automatic logic [3:0] exp_pix(input int h, input int v, input logic bank);
      int w;
      logic [3:0] p;
      w = (v / S) * 8 + (h / S) / 8;
      p = w[3:0];
      return bank ? ~p : p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      swap_req = 1'b0;
      addr_bad = 0; sel_bad = 0; de_bad = 0; hs_bad = 0; vs_bad = 0;
      fs_bad = 0; pix_bad = 0; bank_bad = 0; ack_bad = 0;
      de_cnt = 0; hs_low = 0; hs_fall = 0; vs_low = 0; vs_fall = 0;
      fs_cnt = 0; ack_cnt = 0; line0_chg = 0;
      a_first = -1; a_l0_end = -1; a_last_beg = -1; a_last_end = -1;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_addr = '0;

      tick();
      tick();
      check("rst_bank",    mem_bank,    0);
      check("rst_pix",     pix_out,     0);
      check("rst_de",      de,          0);
      check("rst_hsync_n", hsync_n,     1);
      check("rst_vsync_n", vsync_n,     1);
      check("rst_ack",     swap_ack,    0);
      check("rst_fs",      frame_start, 0);
      check("rst_pix_sel", mem_pix_sel, 0);

      // Counters sit at state 0 from here; after k clock edges they hold state k.
      rst_n = 1'b1;

      for (int k = 1; k <= K_END; k++) begin
         swap_req = ((k - 1) == REQ1) || ((k - 1) == REQ2) ||
                    ((k - 1) == REQ3) || ((k - 1) == REQ4);
         tick();

         sa = k - 1;
         ha = (sa % FR) % HT;
         va = (sa % FR) / HT;
         if (ha < HA && va < VA) begin
            if (mem_addr !== 9'((va / S) * 8 + (ha / S) / 8)) addr_bad++;
         end
         if (k == 1)                 a_first    = int'(mem_addr);
         if (k == HA)                a_l0_end   = int'(mem_addr);
         if (k == (VA - 1) * HT + 1)  a_last_beg = int'(mem_addr);
         if (k == (VA - 1) * HT + HA) a_last_end = int'(mem_addr);
         if (k >= 2 && k <= HA && mem_addr !== prev_addr) line0_chg++;
         prev_addr = mem_addr;

         ss = k - 2;
         if (ss >= 0) begin
            hs = (ss % FR) % HT;
            vs = (ss % FR) / HT;
            if (hs < HA && vs < VA && mem_pix_sel !== 3'((hs / S) % 8)) sel_bad++;
         end

         so = k - 3;
         if (so < 0) begin
            e_de = 1'b0; e_hs_n = 1'b1; e_vs_n = 1'b1; e_fs = 1'b0; e_pix = 4'd0;
         end else begin
            ho = (so % FR) % HT;
            vo = (so % FR) / HT;
            fi = so / FR;
            e_de   = (ho < HA) && (vo < VA);
            e_hs_n = !((ho >= HA + HFP) && (ho < HA + HFP + HSY));
            e_vs_n = !((vo >= VA + VFP) && (vo < VA + VFP + VSY));
            e_fs   = (ho == 0) && (vo == 0);
            e_pix  = e_de ? exp_pix(ho, vo, fi == 1) : 4'd0;
         end
         if (de !== e_de)           de_bad++;
         if (hsync_n !== e_hs_n)    hs_bad++;
         if (vsync_n !== e_vs_n)    vs_bad++;
         if (frame_start !== e_fs)  fs_bad++;
         if (pix_out !== e_pix)     pix_bad++;

         e_bank = (k >= K_ACK1) && (k < K_ACK2);
         e_ack  = (k == K_ACK1) || (k == K_ACK2);
         if (mem_bank !== e_bank)   bank_bad++;
         if (swap_ack !== e_ack)    ack_bad++;
         if (swap_ack === 1'b1)     ack_cnt++;

         if (so >= 0 && so < FR) begin
            if (de === 1'b1) de_cnt++;
            if (hsync_n === 1'b0) hs_low++;
            if (prev_hs === 1'b1 && hsync_n === 1'b0) hs_fall++;
            if (vsync_n === 1'b0) vs_low++;
            if (prev_vs === 1'b1 && vsync_n === 1'b0) vs_fall++;
            if (frame_start === 1'b1) fs_cnt++;
            prev_hs = hsync_n;
            prev_vs = vsync_n;
         end
      end
      swap_req = 1'b0;

      check("frame_de_cycles",   de_cnt,  12288);
      check("frame_hsync_low",   hs_low,  816);
      check("frame_hsync_pulse", hs_fall, 102);
      check("frame_vsync_low",   vs_low,  288);
      check("frame_vsync_pulse", vs_fall, 1);
      check("frame_start_count", fs_cnt,  1);
      check("addr_line0_first",  a_first,    0);
      check("addr_line0_last",   a_l0_end,   7);
      check("addr_lastline_first", a_last_beg, 376);
      check("addr_lastline_last",  a_last_end, 383);
      check("addr_line0_changes",  line0_chg,  7);
      check("addr_mismatches",   addr_bad, 0);
      check("pix_sel_mismatches", sel_bad, 0);
      check("de_mismatches",     de_bad,   0);
      check("hsync_mismatches",  hs_bad,   0);
      check("vsync_mismatches",  vs_bad,   0);
      check("fs_mismatches",     fs_bad,   0);
      check("pix_mismatches",    pix_bad,  0);
      check("bank_mismatches",   bank_bad, 0);
      check("ack_mismatches",    ack_bad,  0);
      check("ack_total",         ack_cnt,  2);

      // Run into the active area of frame 3 with a flip still pending.
      kk = K_END;
      while (kk < K_RST) begin
         tick();
         kk++;
      end
      check("pre_rst_de",  de,      1);
      check("pre_rst_pix", pix_out, 8);

      #2 rst_n = 1'b0;
      #1;
      check("async_rst_de",      de,          0);
      check("async_rst_pix",     pix_out,     0);
      check("async_rst_hsync_n", hsync_n,     1);
      check("async_rst_vsync_n", vsync_n,     1);
      check("async_rst_fs",      frame_start, 0);
      check("async_rst_ack",     swap_ack,    0);
      check("async_rst_bank",    mem_bank,    0);
      check("async_rst_pix_sel", mem_pix_sel, 0);

      tick();
      tick();
      tick();
      rst_n = 1'b1;
      n = 0;
      while (frame_start !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("restart_fs_latency", n,        3);
      check("restart_bank",       mem_bank, 0);
      check("restart_de",         de,       1);
      check("restart_pix",        pix_out,  0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
